// File: rtl/simple_circuit_sweep_ctrl_if.sv
// Bundle between the sweep controller, the lab top level (start/abort, result LEDs)
// and the 3-input/2-output circuit under test.
interface simple_circuit_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic [2:0] abc_out;
  logic       d_in;
  logic       e_in;
  logic       busy;
  logic       sample_valid;
  logic       mismatch;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic       first_err_valid;
  logic [2:0] first_err_vec;

  modport master (
    input  start, abort, d_in, e_in,
    output abc_out, busy, sample_valid, mismatch, done, pass,
           err_count, first_err_valid, first_err_vec
  );

  modport slave (
    output start, abort, d_in, e_in,
    input  abc_out, busy, sample_valid, mismatch, done, pass,
           err_count, first_err_valid, first_err_vec
  );
endinterface

// File: rtl/simple_circuit_sweep_ctrl.sv
// Sweeps all eight A/B/C vectors through the lab circuit, holds each for a settle
// window, and checks D/E against the golden D=(A&B)|~C, E=~C.
module simple_circuit_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  simple_circuit_sweep_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       sv_q, sv_d;
  logic       mm_q, mm_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic       fev_q, fev_d;
  logic [2:0] fvec_q, fvec_d;

  logic gd, ge, fail;

  assign gd   = (vec_q[2] & vec_q[1]) | ~vec_q[0];
  assign ge   = ~vec_q[0];
  assign fail = (bus.d_in != gd) | (bus.e_in != ge);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    sv_d    = 1'b0;
    mm_d    = 1'b0;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fvec_d  = fvec_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          vec_d   = 3'd0;
          cnt_d   = 8'd0;
          err_d   = 4'd0;
          fev_d   = 1'b0;
          fvec_d  = 3'd0;
          pass_d  = 1'b0;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (bus.abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_SAMPLE: begin
        // An abort here drops the sample entirely: nothing counted, nothing reported.
        if (bus.abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          sv_d = 1'b1;
          mm_d = fail;
          if (fail) begin
            err_d = err_q + 4'd1;
            if (!fev_q) begin
              fev_d  = 1'b1;
              fvec_d = vec_q;
            end
          end
          if (vec_q == 3'd7) begin
            done_d  = 1'b1;
            pass_d  = (err_d == 4'd0);
            state_d = ST_DONE;
          end else begin
            vec_d   = vec_q + 3'd1;
            cnt_d   = 8'd0;
            state_d = ST_SETTLE;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // busy is registered from the next state so it lines up with abc_out.
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      sv_q    <= 1'b0;
      mm_q    <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      fev_q   <= 1'b0;
      fvec_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      sv_q    <= sv_d;
      mm_q    <= mm_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fvec_q  <= fvec_d;
    end
  end

  assign bus.abc_out         = vec_q;
  assign bus.busy            = busy_q;
  assign bus.sample_valid    = sv_q;
  assign bus.mismatch        = mm_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_vec   = fvec_q;

endmodule

// File: tb/tb_simple_circuit_sweep_ctrl.sv
// Scoreboard bench: two controllers (settle 4 and settle 1) driving a faultable circuit
// stub; expected samples/done records are queued at start and popped by a monitor.
module tb_simple_circuit_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Truth tables of the lab circuit, indexed by {A,B,C}.
  localparam logic [7:0] GD = 8'hD5;
  localparam logic [7:0] GE = 8'h55;

  typedef struct packed {
    int         cyc;
    logic       mm;
    logic [3:0] err;
  } samp_t;

  typedef struct packed {
    int         cyc;
    logic       pass;
    logic [3:0] err;
    logic       fev;
    logic [2:0] fvec;
  } done_t;

  samp_t sq[2][$];
  done_t dq[2][$];

  int         fm[2];
  logic [1:0] start_r = 2'b00;
  logic [1:0] abort_r = 2'b00;

  simple_circuit_sweep_ctrl_if bus4 ();
  simple_circuit_sweep_ctrl_if bus1 ();

  simple_circuit_sweep_ctrl #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  simple_circuit_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Circuit stub: 0 ideal, 1 E stuck 0, 2 D stuck 0, 3 D inverted only for vector 5.
  function automatic logic [1:0] circuit(input int mode, input logic [2:0] v);
    logic d, e;
    d = (v[2] & v[1]) | ~v[0];
    e = ~v[0];
    case (mode)
      1: e = 1'b0;
      2: d = 1'b0;
      3: if (v == 3'd5) d = ~d;
      default: ;
    endcase
    return {d, e};
  endfunction

  assign bus4.start = start_r[0];
  assign bus4.abort = abort_r[0];
  assign bus1.start = start_r[1];
  assign bus1.abort = abort_r[1];
  assign {bus4.d_in, bus4.e_in} = circuit(fm[0], bus4.abc_out);
  assign {bus1.d_in, bus1.e_in} = circuit(fm[1], bus1.abc_out);

  logic        sv_w[2], mm_w[2], done_w[2], pass_w[2], busy_w[2], fev_w[2];
  logic [3:0]  err_w[2];
  logic [2:0]  fvec_w[2];
  logic [15:0] outs_w[2];

  assign sv_w[0] = bus4.sample_valid;    assign sv_w[1] = bus1.sample_valid;
  assign mm_w[0] = bus4.mismatch;        assign mm_w[1] = bus1.mismatch;
  assign done_w[0] = bus4.done;          assign done_w[1] = bus1.done;
  assign pass_w[0] = bus4.pass;          assign pass_w[1] = bus1.pass;
  assign busy_w[0] = bus4.busy;          assign busy_w[1] = bus1.busy;
  assign fev_w[0] = bus4.first_err_valid; assign fev_w[1] = bus1.first_err_valid;
  assign err_w[0] = bus4.err_count;      assign err_w[1] = bus1.err_count;
  assign fvec_w[0] = bus4.first_err_vec; assign fvec_w[1] = bus1.first_err_vec;
  assign outs_w[0] = {bus4.abc_out, bus4.busy, bus4.sample_valid, bus4.mismatch, bus4.done,
                      bus4.pass, bus4.err_count, bus4.first_err_valid, bus4.first_err_vec};
  assign outs_w[1] = {bus1.abc_out, bus1.busy, bus1.sample_valid, bus1.mismatch, bus1.done,
                      bus1.pass, bus1.err_count, bus1.first_err_valid, bus1.first_err_vec};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int s_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic string pfx(input int i);
    return (i == 0) ? "s4 " : "s1 ";
  endfunction

  function automatic logic fails(input int mode, input int v);
    logic [1:0] got;
    logic [1:0] want;
    got  = circuit(mode, 3'(v));
    want = {GD[v], GE[v]};
    return got != want;
  endfunction

  // Outcome after the first nvec vectors of a sweep have been compared.
  task automatic model(input int mode, input int nvec,
                       output logic [3:0] err, output logic fev, output logic [2:0] fvec);
    err = 4'd0; fev = 1'b0; fvec = 3'd0;
    for (int v = 0; v < nvec; v++) begin
      if (fails(mode, v)) begin
        err++;
        if (!fev) begin fev = 1'b1; fvec = 3'(v); end
      end
    end
  endtask

  task automatic push_expect(input int i, input int k);
    int s;
    logic [3:0] err; logic fev; logic [2:0] fvec;
    s = s_of(i);
    for (int v = 0; v < 8; v++) begin
      model(fm[i], v + 1, err, fev, fvec);
      sq[i].push_back('{cyc: k + 2 + v * (s + 1) + s, mm: fails(fm[i], v), err: err});
    end
    model(fm[i], 8, err, fev, fvec);
    dq[i].push_back('{cyc: k + 1 + 8 * (s + 1), pass: (err == 4'd0), err: err, fev: fev, fvec: fvec});
  endtask

  // Monitor: pops expected records whenever the DUT reports, flags missing ones by cycle.
  task automatic monitor_one(input int i);
    int    now;
    samp_t s;
    done_t d;
    now = cyc + 1;
    if (sv_w[i]) begin
      if (sq[i].size() == 0) check({pfx(i), "sample_unexpected"}, sv_w[i], 0);
      else begin
        s = sq[i].pop_front();
        check({pfx(i), "sample_cycle"}, now, s.cyc);
        check({pfx(i), "mismatch"}, mm_w[i], s.mm);
        check({pfx(i), "err_running"}, err_w[i], s.err);
      end
    end else if (sq[i].size() > 0 && sq[i][0].cyc < now) begin
      s = sq[i].pop_front();
      check({pfx(i), "sample_missing"}, sv_w[i], 1);
    end
    if (done_w[i]) begin
      if (dq[i].size() == 0) check({pfx(i), "done_unexpected"}, done_w[i], 0);
      else begin
        d = dq[i].pop_front();
        check({pfx(i), "done_cycle"}, now, d.cyc);
        check({pfx(i), "pass"}, pass_w[i], d.pass);
        check({pfx(i), "err_count"}, err_w[i], d.err);
        check({pfx(i), "first_err_valid"}, fev_w[i], d.fev);
        check({pfx(i), "first_err_vec"}, fvec_w[i], d.fvec);
        check({pfx(i), "busy_at_done"}, busy_w[i], 0);
      end
    end else if (dq[i].size() > 0 && dq[i][0].cyc < now) begin
      d = dq[i].pop_front();
      check({pfx(i), "done_missing"}, done_w[i], 1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) monitor_one(i);
    end
  end

  task automatic begin_sweep(input int i, input int mode, output int k);
    @(negedge clk);
    fm[i] = mode;
    start_r[i] = 1'b1;
    k = cyc + 1;
    push_expect(i, k);
    @(negedge clk);
    start_r[i] = 1'b0;
  endtask

  // repulse/abort_at: cycle offsets from k (0 = unused).
  task automatic run_sweep(input int i, input int mode, input int repulse, input int abort_at);
    int k, s, now, nv;
    logic seen;
    logic [3:0] err; logic fev; logic [2:0] fvec;
    s = s_of(i);
    seen = 1'b0;
    begin_sweep(i, mode, k);
    for (int n = 0; n < 8 * (s + 1) + 20 && !seen; n++) begin
      now = cyc + 1;
      start_r[i] = (repulse != 0) && (now == k + repulse);
      if (abort_at != 0 && now == k + abort_at) begin
        abort_r[i] = 1'b1;
        while (sq[i].size() > 0 && sq[i][$].cyc > now) void'(sq[i].pop_back());
        dq[i].delete();
        nv = 0;
        for (int v = 0; v < 8; v++) if (k + 2 + v * (s + 1) + s <= now) nv++;
        model(mode, nv, err, fev, fvec);
        @(negedge clk);
        abort_r[i] = 1'b0;
        check({pfx(i), "abort_busy"}, busy_w[i], 0);
        check({pfx(i), "abort_pass"}, pass_w[i], 0);
        check({pfx(i), "abort_err"}, err_w[i], err);
        check({pfx(i), "abort_fev"}, fev_w[i], fev);
        check({pfx(i), "abort_fvec"}, fvec_w[i], fvec);
        repeat (40) @(negedge clk);
        return;
      end
      if (done_w[i]) seen = 1'b1;
      else @(negedge clk);
    end
    start_r[i] = 1'b0;
    if (!seen) check({pfx(i), "done_timeout"}, done_w[i], 1);
  endtask

  initial begin
    int k;
    fm[0] = 0;
    fm[1] = 0;
    #1;
    check("s4 reset_outputs", outs_w[0], 0);
    check("s1 reset_outputs", outs_w[1], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_sweep(0, 0, 0, 0);    // ideal, S=4
    run_sweep(0, 1, 0, 0);    // E stuck 0
    run_sweep(0, 2, 0, 0);    // D stuck 0
    run_sweep(0, 3, 0, 0);    // D wrong only on vector 5
    run_sweep(0, 0, 17, 0);   // start re-pulsed during vector 3
    run_sweep(0, 1, 0, 18);   // abort in vector 3 settle
    run_sweep(0, 1, 0, 15);   // abort in vector 2 sample cycle
    run_sweep(1, 0, 0, 0);    // ideal, S=1
    run_sweep(1, 2, 0, 0);

    // Asynchronous reset between edges in the middle of vector 1's settle window.
    begin_sweep(0, 2, k);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin sq[i].delete(); dq[i].delete(); end
    #1;
    check("s4 async_reset_outputs", outs_w[0], 0);
    check("s1 async_reset_outputs", outs_w[1], 0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, 0, 0, 0);

    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_sweep($urandom_range(0, 1), $urandom_range(0, 3), 0, 0);
    end

    repeat (5) @(negedge clk);
    check("s4 queue_empty", sq[0].size() + dq[0].size(), 0);
    check("s1 queue_empty", sq[1].size() + dq[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/simple_circuit_sweep_ctrl.md
# simple_circuit_sweep_ctrl

Self-checking sweep controller for the 3-input/2-output lab combinational circuit (D = (A&B) | ~C, E = ~C). On a start request it drives all eight A/B/C combinations in order, holds each for a programmable settle window so that propagation-delay variants of the circuit resolve, samples D/E and compares them against an internal golden model. It sits between the lab top level (start/abort, result LEDs) and the circuit under test, replacing hand-written stimulus blocks.

## Interface
- SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range 1..255
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous and active-high
- start  input  1  sweep request; honoured only in IDLE
- abort  input  1  cancel the sweep in progress; ignored in IDLE
- abc_out  output  3  vector to the circuit: [2]=A, [1]=B, [0]=C
- d_in  input  1  D from the circuit
- e_in  input  1  E from the circuit
- busy  output  1  high in SETTLE and SAMPLE
- sample_valid  output  1  one-cycle pulse per compared vector
- mismatch  output  1  valid with sample_valid; 1 = this vector failed
- done  output  1  one-cycle pulse at sweep completion
- pass  output  1  err_count==0 at last completion; held until next start, abort or reset
- err_count  output  4  failing vectors in the current/last sweep, 0..8
- first_err_valid  output  1  at least one failure seen this sweep
- first_err_vec  output  3  index of the first failing vector

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
- Reset (asynchronous, any state): state=IDLE, abc_out=0, busy=0, sample_valid=0, mismatch=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_vec=0, settle counter=0.
- IDLE + start: vec=0, counter=0, err_count=0, first_err_valid=0, first_err_vec=0, pass=0, go to SETTLE.
- SETTLE: counter increments each cycle. At counter==SETTLE_CYCLES-1, go to SAMPLE. abc_out stays constant.
- SAMPLE, one cycle:
  - Golden values: gd=(vec[2]&vec[1])|~vec[0], ge=~vec[0].
  - Failure: (d_in!=gd)|(e_in!=ge). A vector counts at most once.
  - On failure, err_count increments. If first_err_valid==0, latch first_err_vec=vec and set first_err_valid.
  - Pulse sample_valid with mismatch.
  - If vec==7, go to DONE. Otherwise vec=vec+1, counter=0, go to SETTLE.
- DONE, one cycle: done=1, pass=(err_count==0), go to IDLE. abc_out keeps 7 until the next start.
- Abort in SETTLE or SAMPLE: go to IDLE on the next edge. No done pulse, pass=0. err_count and first_err fields keep their partial values. An abort in a SAMPLE cycle discards that sample: no count and no sample_valid.
- start outside IDLE, including the DONE cycle, is ignored. abort and start together in IDLE: start wins.

## Timing
- Call the edge that samples start in IDLE edge k, and let S=SETTLE_CYCLES.
- busy=1 and abc_out=0 from k+1.
- Vector i is driven from cycle k+1+i(S+1), for S+1 cycles. It is sampled in its last cycle, k+1+i(S+1)+S.
- sample_valid for vector i is high in cycle k+2+i(S+1)+S.
- done is high in cycle k+1+8(S+1). busy is already 0 in that cycle.
- With S=4, done is high in cycle k+41. Total sweep is 8(S+1) cycles.
- Back-to-back sweeps: the earliest accepted restart is the cycle after done.

## Test plan
- Ideal circuit model, S=4, start pulse at edge k -> abc_out steps 0..7 every 5 cycles, 8 sample_valid pulses all with mismatch=0, done at k+41, pass=1, err_count=0, first_err_valid=0.
- e_in stuck at 0 -> vectors 0,2,4,6 fail, err_count=4, first_err_vec=0, pass=0.
- d_in stuck at 0 -> vectors 0,2,4,6,7 fail, err_count=5, first_err_vec=0. Then D forced wrong only for vector 5 -> err_count=1, first_err_vec=5.
- start re-pulsed while busy at vector 3 -> ignored, single done at k+41. abort during vector 3 SETTLE -> IDLE next edge, no done, pass=0, busy=0.
- rst asserted mid-SETTLE between clock edges -> all outputs at reset values immediately. A later start runs a full clean sweep with pass=1.
- S=1 -> each vector held 2 cycles, done at k+17. Ideal model gives pass=1.
